// File: rtl/axis_1553_decoder.sv
// MIL-STD-1553 Manchester receiver: finds the sync, decodes 16 data bits plus parity and emits one AXI-Stream beat per word.
// tvalid rises within one aclk of the last parity sample; an unaccepted beat is overwritten by the next word.
module axis_1553_decoder #(
  parameter int clock_speed = 100000000,
  parameter int sample_rate = 2000000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tuser,
  input  logic        m_axis_tready
);

  localparam int DIV  = clock_speed / sample_rate;
  localparam int SPB  = sample_rate / 1000000;
  localparam int HALF = SPB / 2;
  localparam int SYNC = (3 * SPB) / 2;
  localparam int PW   = $clog2(DIV) + 1;
  localparam int CW   = $clog2(4 * SPB) + 2;
  localparam int GW   = CW + 2;
  localparam logic [PW-1:0] PH_RESTART = (DIV >= 2) ? PW'(DIV / 2 - 1) : '0;

  typedef enum logic [1:0] {S_HUNT, S_SYNC_CHECK, S_DATA, S_OUTPUT} state_t;

  state_t          r_state;
  logic [1:0]      r_meta, r_sync, r_sync_d;
  logic [PW-1:0]   r_ph;
  logic            r_pv, r_pl;
  logic [CW-1:0]   r_run, r_cnt;
  logic [GW-1:0]   r_gap;
  logic            r_have_prev;
  logic [4:0]      r_bit;
  logic [16:0]     r_sh;
  logic            r_h1, r_type, r_contig;
  logic            r_tvalid;
  logic [15:0]     r_tdata;
  logic [7:0]      r_tuser;

  logic w_vld, w_lvl, w_trans, w_smp, w_same;
  logic w_sync_start, w_contig, w_half_bad, w_word_end;

  assign w_vld   = r_sync[1] ^ r_sync[0];
  assign w_lvl   = r_sync[1];
  assign w_trans = w_vld && (r_sync != r_sync_d);
  // A transition re-centres the sampler; never also sample on the edge cycle itself.
  assign w_smp   = (r_ph == '0) && !(w_trans && (DIV > 1));
  assign w_same  = w_vld && r_pv && (w_lvl == r_pl);

  assign w_sync_start = w_smp && w_vld && r_pv && (w_lvl != r_pl) &&
                        (r_run >= CW'(SYNC - 1)) && (r_run <= CW'(SYNC + 1));
  // Idle between the previous word and this sync is r_gap - r_run samples.
  assign w_contig     = r_have_prev && (({2'b00, r_run} + GW'(2 * SPB)) >= r_gap);
  assign w_half_bad   = (r_cnt == CW'(HALF)) && (w_lvl == r_h1);
  assign w_word_end   = (r_state == S_DATA) && w_smp && w_vld && !w_half_bad &&
                        (r_cnt == CW'(SPB - 1)) && (r_bit == 5'd16);

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_meta      <= '0;
      r_sync      <= '0;
      r_sync_d    <= '0;
      r_ph        <= '0;
      r_pv        <= 1'b0;
      r_pl        <= 1'b0;
      r_run       <= '0;
      r_gap       <= '0;
      r_have_prev <= 1'b0;
    end else begin
      r_meta   <= diff;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      if (w_trans && (DIV > 1)) r_ph <= PH_RESTART;
      else if (r_ph == '0)      r_ph <= PW'(DIV - 1);
      else                      r_ph <= r_ph - 1'b1;
      if (w_smp) begin
        r_pv <= w_vld;
        r_pl <= w_lvl;
        // Run length restarts at a word boundary so a back-to-back sync measures only itself.
        if (w_word_end || !w_vld) r_run <= '0;
        else if (w_same) begin
          if (r_run != '1) r_run <= r_run + 1'b1;
        end else r_run <= CW'(1);
        if (w_word_end) begin
          r_gap       <= '0;
          r_have_prev <= 1'b1;
        end else if (r_gap != '1) begin
          r_gap <= r_gap + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_state  <= S_HUNT;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_sh     <= '0;
      r_h1     <= 1'b0;
      r_type   <= 1'b0;
      r_contig <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
    end else begin
      if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (w_sync_start) begin
            r_state  <= S_SYNC_CHECK;
            r_cnt    <= CW'(1);
            r_type   <= r_pl;
            r_contig <= w_contig;
          end
        end
        S_SYNC_CHECK: begin
          if (w_smp) begin
            if (w_vld && (w_lvl != r_type)) begin
              if (r_cnt == CW'(SYNC - 1)) begin
                r_state <= S_DATA;
                r_cnt   <= '0;
                r_bit   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (w_sync_start) begin
              r_cnt    <= CW'(1);
              r_type   <= r_pl;
              r_contig <= w_contig;
            end else begin
              r_state <= S_HUNT;
            end
          end
        end
        S_DATA: begin
          if (w_smp) begin
            if (!w_vld || w_half_bad) begin
              r_state <= S_HUNT;
            end else begin
              if (r_cnt == '0) r_h1 <= w_lvl;
              if (r_cnt == CW'(HALF)) r_sh <= {r_sh[15:0], r_h1};
              if (r_cnt == CW'(SPB - 1)) begin
                r_cnt <= '0;
                r_bit <= r_bit + 1'b1;
                if (r_bit == 5'd16) r_state <= S_OUTPUT;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end
        S_OUTPUT: begin
          r_tdata  <= r_sh[16:1];
          r_tuser  <= {(r_type ? 3'b100 : 3'b010), 3'b000, r_contig, ^r_sh};
          r_tvalid <= 1'b1;
          r_state  <= S_HUNT;
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;

endmodule

// File: tb/tb_axis_1553_decoder.sv
// Directed bench for axis_1553_decoder: drives Manchester words on diff and checks the output beats.
module tb_axis_1553_decoder;

  localparam int CLK_P    = 10;
  localparam int HALF_CYC = 50;

  logic        aclk = 1'b0;
  logic        arstn;
  logic [1:0]  diff;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tready;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [23:0] beats[$];
  time         t_rise = 0;
  time         t0, t1;
  logic        prev_vld = 1'b0;
  logic        mon_stall = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;
  int          n_chg = 0;
  int          n_drop = 0;

  always #(CLK_P / 2) aclk = ~aclk;

  axis_1553_decoder dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .diff          (diff),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready)
  );

  always @(negedge aclk) begin
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) beats.push_back({m_axis_tdata, m_axis_tuser});
    if (m_axis_tvalid === 1'b1 && prev_vld !== 1'b1) t_rise = $time;
    prev_vld = m_axis_tvalid;
    if (mon_stall) begin
      if (prev_stall && m_axis_tvalid !== 1'b1) n_drop++;
      if (prev_stall && m_axis_tvalid === 1'b1 && m_axis_tdata !== prev_dat) n_chg++;
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
      prev_dat   = m_axis_tdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] lv(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  function automatic logic op(input logic [15:0] d);
    return ~^d;
  endfunction

  function automatic logic [7:0] tu(input logic cmd, input logic contig, input logic pg);
    return {(cmd ? 3'b100 : 3'b010), 3'b000, contig, pg};
  endfunction

  task automatic drv(input logic [1:0] d, input int cyc);
    diff = d;
    repeat (cyc) @(negedge aclk);
  endtask

  task automatic idle(input int us);
    drv(2'b11, us * 100);
  endtask

  task automatic set_ready(input logic v);
    @(posedge aclk);
    #1 m_axis_tready = v;
    @(negedge aclk);
  endtask

  task automatic send_bit(input logic b, input logic bad, input logic rst);
    logic [1:0] first;
    first = bad ? 2'b10 : lv(b);
    if (rst) begin
      diff  = first;
      arstn = 1'b0;
      repeat (5) @(negedge aclk);
      arstn = 1'b1;
      drv(first, HALF_CYC - 5);
    end else begin
      drv(first, HALF_CYC);
    end
    drv(bad ? 2'b10 : lv(~b), HALF_CYC);
  endtask

  task automatic send_word(input logic cmd, input logic [15:0] d, input logic p,
                           input int bad_bit, input int rst_bit);
    drv(lv(cmd), 3 * HALF_CYC);
    drv(lv(~cmd), 3 * HALF_CYC);
    for (int i = 15; i >= 0; i--) send_bit(d[i], i == bad_bit, i == rst_bit);
    send_bit(p, 1'b0, 1'b0);
  endtask

  task automatic pop_beat(input string tag, input logic [15:0] d, input logic [7:0] u);
    logic [23:0] b;
    b = 'x;
    if (beats.size() > 0) b = beats.pop_front();
    chk({tag, "_dat"}, 32'(b[23:8]), 32'(d));
    chk({tag, "_usr"}, 32'(b[7:0]), 32'(u));
  endtask

  initial begin
    arstn = 1'b0;
    diff = 2'b11;
    m_axis_tready = 1'b1;
    repeat (4) @(negedge aclk);
    chk("rst_vld", 32'(m_axis_tvalid), 32'd0);
    chk("rst_dat", 32'(m_axis_tdata), 32'd0);
    chk("rst_usr", 32'(m_axis_tuser), 32'd0);
    arstn = 1'b1;
    idle(5);
    chk("idle_vld", 32'(m_axis_tvalid), 32'd0);
    chk("idle_beats", 32'(beats.size()), 32'd0);

    // Command sync, all ones, good parity; also bound the output latency.
    t0 = $time;
    send_word(1'b1, 16'hFFFF, 1'b1, -1, -1);
    t1 = $time;
    idle(5);
    chk("ffff_cnt", 32'(beats.size()), 32'd1);
    pop_beat("ffff", 16'hFFFF, 8'h81);
    chk("ffff_lat", 32'((t_rise > t0) && (t_rise <= t1 + 104 * CLK_P)), 32'd1);

    send_word(1'b0, 16'h0000, 1'b1, -1, -1);
    idle(5);
    chk("zero_cnt", 32'(beats.size()), 32'd1);
    pop_beat("zero", 16'h0000, 8'h41);

    send_word(1'b0, 16'h0001, 1'b1, -1, -1);
    idle(5);
    chk("badpar_cnt", 32'(beats.size()), 32'd1);
    pop_beat("badpar", 16'h0001, 8'h40);

    // Gapless counting stream.
    for (int i = 0; i <= 16; i++) send_word(1'b0, 16'(i), op(16'(i)), -1, -1);
    idle(5);
    chk("strm_cnt", 32'(beats.size()), 32'd17);
    for (int i = 0; i <= 16; i++) pop_beat($sformatf("strm%0d", i), 16'(i), tu(1'b0, i != 0, 1'b1));

    // Equal halves on bit 7 kill the word; the following word must still decode.
    send_word(1'b1, 16'h1234, op(16'h1234), 7, -1);
    idle(5);
    chk("manch_cnt", 32'(beats.size()), 32'd0);
    send_word(1'b1, 16'hA5C3, op(16'hA5C3), -1, -1);
    idle(5);
    chk("after_cnt", 32'(beats.size()), 32'd1);
    pop_beat("after", 16'hA5C3, tu(1'b1, 1'b0, 1'b1));

    // Stall across two words: second overwrites, held stable, single beat.
    set_ready(1'b0);
    mon_stall = 1'b1;
    send_word(1'b0, 16'h1111, op(16'h1111), -1, -1);
    idle(5);
    chk("stall1_vld", 32'(m_axis_tvalid), 32'd1);
    chk("stall1_dat", 32'(m_axis_tdata), 32'h1111);
    send_word(1'b1, 16'h2222, op(16'h2222), -1, -1);
    idle(5);
    chk("stall2_vld", 32'(m_axis_tvalid), 32'd1);
    chk("stall2_dat", 32'(m_axis_tdata), 32'h2222);
    chk("stall_beats", 32'(beats.size()), 32'd0);
    mon_stall = 1'b0;
    set_ready(1'b1);
    idle(2);
    chk("stall_cnt", 32'(beats.size()), 32'd1);
    pop_beat("stall", 16'h2222, tu(1'b1, 1'b0, 1'b1));
    chk("stall_vld_drop", 32'(m_axis_tvalid), 32'd0);
    chk("stall_changes", 32'(n_chg), 32'd1);
    chk("stall_drops", 32'(n_drop), 32'd0);

    // Reset mid-word clears a pending beat and discards the partial word.
    set_ready(1'b0);
    send_word(1'b0, 16'h00FF, op(16'h00FF), -1, -1);
    idle(5);
    chk("pend_vld", 32'(m_axis_tvalid), 32'd1);
    send_word(1'b0, 16'h0F0F, op(16'h0F0F), -1, 8);
    chk("mrst_vld", 32'(m_axis_tvalid), 32'd0);
    chk("mrst_dat", 32'(m_axis_tdata), 32'd0);
    chk("mrst_usr", 32'(m_axis_tuser), 32'd0);
    idle(5);
    set_ready(1'b1);
    idle(2);
    chk("mrst_cnt", 32'(beats.size()), 32'd0);
    send_word(1'b1, 16'hBEEF, op(16'hBEEF), -1, -1);
    idle(5);
    chk("post_cnt", 32'(beats.size()), 32'd1);
    pop_beat("post", 16'hBEEF, tu(1'b1, 1'b0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
